// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Registers the decoded control bundles and operands for EX. A dependent
// instruction behind a load gets a one-cycle bubble, and the instruction in
// ID is squashed on a taken branch or jump.
// Optional build macro: LOADUSE_PERF_EN enables the load-use bubble counter.
// When it is undefined, bubble_cnt is tied to zero.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    WB_in,
  input  logic [1:0]    M_in,
  input  logic [3:0]    EX_in,
  input  logic [DW-1:0] pc4_in,
  input  logic [DW-1:0] rd1_in,
  input  logic [DW-1:0] rd2_in,
  input  logic [DW-1:0] imm_in,
  input  logic [RW-1:0] rs_in,
  input  logic [RW-1:0] rt_in,
  input  logic [RW-1:0] rd_in,
  input  logic          flush,
  input  logic          hold,
  output logic [1:0]    WB_out,
  output logic [1:0]    M_out,
  output logic [3:0]    EX_out,
  output logic [DW-1:0] pc4_out,
  output logic [DW-1:0] rd1_out,
  output logic [DW-1:0] rd2_out,
  output logic [DW-1:0] imm_out,
  output logic [RW-1:0] rs_out,
  output logic [RW-1:0] rt_out,
  output logic [RW-1:0] rd_out,
  output logic          valid_out,
  output logic          stall,
  output logic [15:0]   bubble_cnt
);

  logic [1:0]    r_wb;
  logic [1:0]    r_m;
  logic [3:0]    r_ex;
  logic [DW-1:0] r_pc4;
  logic [DW-1:0] r_rd1;
  logic [DW-1:0] r_rd2;
  logic [DW-1:0] r_imm;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_rd;
  logic          r_valid;

  logic          w_stall;
  logic          w_bubble;

  // A load sitting here whose destination matches either ID source needs a
  // bubble. A load to $0 never stalls because $0 is never written.
  assign w_stall  = r_valid & r_m[1] & (r_rt != '0) &
                    ((r_rt == rs_in) | (r_rt == rt_in));
  assign w_bubble = flush | w_stall;

  // Pipeline register: reset, then freeze, then bubble, then normal load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb    <= '0;
      r_m     <= '0;
      r_ex    <= '0;
      r_pc4   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else if (!hold) begin
      r_pc4 <= pc4_in;
      r_rd1 <= rd1_in;
      r_rd2 <= rd2_in;
      r_imm <= imm_in;
      r_rs  <= rs_in;
      r_rt  <= rt_in;
      r_rd  <= rd_in;
      if (w_bubble) begin
        r_wb    <= '0;
        r_m     <= '0;
        r_ex    <= '0;
        r_valid <= 1'b0;
      end else begin
        r_wb    <= WB_in;
        r_m     <= M_in;
        r_ex    <= EX_in;
        r_valid <= 1'b1;
      end
    end
  end

`ifdef LOADUSE_PERF_EN
  logic [15:0] r_bubble_cnt;

  // Count only bubbles caused by load-use stalls. A flush that lands in the
  // same cycle still counts once. The counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!hold && w_stall && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  assign bubble_cnt = 16'd0;
`endif

  assign WB_out    = r_wb;
  assign M_out     = r_m;
  assign EX_out    = r_ex;
  assign pc4_out   = r_pc4;
  assign rd1_out   = r_rd1;
  assign rd2_out   = r_rd2;
  assign imm_out   = r_imm;
  assign rs_out    = r_rs;
  assign rt_out    = r_rt;
  assign rd_out    = r_rd;
  assign valid_out = r_valid;
  assign stall     = w_stall;

endmodule
